// File: rtl/spi_responder.sv
// spi_responder: SPI mode-3 peripheral serving a 64 x 8 register file.
// SPI pins are oversampled in the clk domain; register 0x00 reads DEVICE_ID.
module spi_responder #(
    parameter logic [7:0] DEVICE_ID   = 8'h33,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_clk,
    input  logic       spi_cs,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic       loc_we,
    input  logic [5:0] loc_addr,
    input  logic [7:0] loc_wdata,
    output logic       wr_strobe,
    output logic [5:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       rd_strobe,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ADDR  = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;
    logic                   cs_prev;

    // Synchronizers keep running through reset so a frame already in
    // flight when rst drops is recognised and drained.
    always_ff @(posedge clk) begin
        sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
        cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
        sclk_prev <= sclk_sync[SYNC_STAGES-1];
        cs_prev   <= cs_sync[SYNC_STAGES-1];
    end

    logic sclk_s;
    logic cs_s;
    logic mosi_s;
    logic sclk_rise;
    logic sclk_fall;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;

    logic [1:0] state;
    logic [2:0] bit_cnt;
    logic [7:0] shift_in;
    logic [7:0] tx;
    logic       rw;
    logic       ms;
    logic [5:0] addr;
    logic [7:0] regs [64];

    logic [7:0] hdr_byte;
    logic [7:0] data_byte;
    logic [5:0] next_addr;
    logic [5:0] fetch_addr;
    logic [7:0] fetch_data;
    logic       byte_done;
    logic       commit_we;

    // Header arrives MSB first, data bytes LSB first.
    assign hdr_byte   = {shift_in[6:0], mosi_s};
    assign data_byte  = {mosi_s, shift_in[7:1]};
    assign next_addr  = addr + 6'd1;
    assign fetch_addr = (state == S_ADDR) ? hdr_byte[5:0] : next_addr;
    assign fetch_data = (fetch_addr == 6'd0) ? DEVICE_ID : regs[fetch_addr];
    assign byte_done  = sclk_rise && (bit_cnt == 3'd7);
    assign commit_we  = !rst && !cs_s && (state == S_DATA) && byte_done
                        && !rw && (addr != 6'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (loc_we && (loc_addr != 6'd0)
                && !(commit_we && (loc_addr == addr))) begin
                regs[loc_addr] <= loc_wdata;
            end
            if (commit_we) begin
                regs[addr] <= data_byte;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            shift_in  <= '0;
            tx        <= '0;
            rw        <= 1'b0;
            ms        <= 1'b0;
            addr      <= '0;
            spi_miso  <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_strobe <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            rd_strobe <= 1'b0;
            frame_err <= 1'b0;
            if (cs_s) begin
                if ((state == S_ADDR)
                    || ((state == S_DATA) && (bit_cnt != 3'd0))) begin
                    frame_err <= 1'b1;
                end
                state    <= S_IDLE;
                spi_miso <= 1'b0;
                rw       <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        bit_cnt  <= '0;
                        shift_in <= '0;
                        spi_miso <= 1'b0;
                        rw       <= 1'b0;
                        ms       <= 1'b0;
                        // CS already low without a fresh edge: stale frame.
                        state    <= cs_prev ? S_ADDR : S_DRAIN;
                    end
                    S_ADDR: begin
                        if (sclk_rise) begin
                            shift_in <= hdr_byte;
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rw    <= hdr_byte[7];
                                ms    <= hdr_byte[6];
                                addr  <= hdr_byte[5:0];
                                state <= S_DATA;
                                if (hdr_byte[7]) begin
                                    tx        <= fetch_data;
                                    rd_strobe <= 1'b1;
                                end
                            end
                        end
                    end
                    S_DATA: begin
                        if (sclk_fall && rw) begin
                            spi_miso <= tx[0];
                            tx       <= {1'b0, tx[7:1]};
                        end
                        if (sclk_rise) begin
                            shift_in <= data_byte;
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (byte_done) begin
                                if (commit_we) begin
                                    wr_strobe <= 1'b1;
                                    wr_addr   <= addr;
                                    wr_data   <= data_byte;
                                end
                                if (ms) begin
                                    addr <= next_addr;
                                    if (rw) begin
                                        tx        <= fetch_data;
                                        rd_strobe <= 1'b1;
                                    end
                                end else begin
                                    state <= S_DRAIN;
                                end
                            end
                        end
                    end
                    S_DRAIN: begin
                        spi_miso <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign spi_miso_oe = rw && ((state == S_DATA) || (state == S_DRAIN));
    assign busy = !rst && !cs_s && ((state != S_IDLE) || cs_prev);

endmodule

// File: doc/spi_responder.md
# spi_responder

SPI responder (peripheral side) for the team's 4-wire sensor link. It decodes frames issued by the SPI initiator and serves them from a 64 x 8 register file. It oversamples the SPI pins in the system clock domain, commits writes, and returns read data on MISO. It sits in the sensor model and loopback fabric, and it is the bench partner for the initiator.

## Interface
- `DEVICE_ID`, 8'h33: constant returned by register 0x00, which is read-only.
- `SYNC_STAGES`, 2: flip-flop stages on the `spi_clk`, `spi_cs` and `spi_mosi` synchronizers (allowed range ≥2).
- `clk` in 1: system clock. One clock domain; all logic updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `spi_clk` in 1: SPI clock. Idles high; mode 3 (CPOL=1, CPHA=1).
- `spi_cs` in 1: chip select, active-low.
- `spi_mosi` in 1: initiator data. Changes on falling `spi_clk` and is sampled on rising.
- `spi_miso` out 1: responder data. Updated after falling `spi_clk`.
- `spi_miso_oe` out 1: MISO output enable. High only while a read data phase is active.
- `loc_we`, `loc_addr[5:0]`, `loc_wdata[7:0]` in: local write port (sensor samples).
- `wr_strobe` out 1; `wr_addr` out 6; `wr_data` out 8: one-cycle pulse with fields for each committed SPI write.
- `rd_strobe` out 1: one-cycle pulse when a read address is latched.
- `frame_err` out 1: one-cycle pulse on a truncated frame.
- `busy` out 1: high while a frame is in progress.

## Operation
- **Frame format.** Byte 0 is {rw, ms, addr[5:0]}, sent MSB first (rw first). Data bytes follow, sent LSB first (bit 0 first).
  - rw = 1 means read; rw = 0 means write.
  - ms = 1 enables burst mode: the address auto-increments after each data byte and wraps from 63 to 0.
  - ms = 0: bytes after the first data byte are ignored.
- **Edge detection.** Edges are found on the synchronized `spi_clk`.
  - A rising edge samples the synchronized MOSI.
  - A falling edge shifts MISO.
  - The synchronized `spi_cs` going high ends the frame.
- **States.** The machine has four states: IDLE, ADDR, DATA, DRAIN.
  - IDLE -> ADDR when the synchronized `spi_cs` goes low. The bit counter is cleared.
  - ADDR -> DATA on the 8th rising edge. rw, ms and addr are latched at this point.
    - For a read, the register is fetched into the shift register and `rd_strobe` pulses.
    - The first falling edge in DATA drives bit 0 of the fetched register.
  - DATA, write: on each 8th rising edge, `regs[addr]` <= the assembled byte and `wr_strobe` pulses.
  - DATA, read: the next register is fetched on each 8th rising edge when ms = 1.
  - DATA -> DRAIN after the first data byte completes when ms = 0.
  - DRAIN: all edges are ignored. MISO is driven 0 with `spi_miso_oe` = 1 if the frame is a read.
  - Any state -> IDLE when `spi_cs` goes high.
- **Truncated frames.** If `spi_cs` goes high while in ADDR, or with 1–7 bits into a data byte:
  - `frame_err` pulses.
  - The partial byte is discarded and no write is committed.
- **Register 0x00.** Reads return `DEVICE_ID`. SPI and local writes to 0x00 are dropped with no `wr_strobe`. In burst mode the address still advances.
- **Write collision.** If an SPI commit and `loc_we` target the same address in the same cycle, the SPI write wins and the local write is lost. If the addresses differ, both writes complete.
- **Read timing.** A read returns the register value at the fetch cycle. Later local writes do not alter the byte being shifted.
- **Outputs outside a read data phase.** `spi_miso` = 0 and `spi_miso_oe` = 0.

## Timing
- **Reset values.** All outputs are 0; registers 0x01–0x3F are 0x00; the state is IDLE.
- **Reset during an active frame.** If the synchronized `spi_cs` is still low when `rst` deasserts, go to DRAIN. Do not decode a partial frame; wait for `spi_cs` high.
- **Pin-to-detection latency.** A pin edge is detected SYNC_STAGES+1 `clk` cycles after it occurs.
  - `wr_strobe`, `rd_strobe` and `frame_err` assert on the cycle after detection and last one cycle.
  - `spi_miso` changes on the cycle after falling-edge detection.
- **Supported SPI rate.** `spi_clk` half-period ≥ SYNC_STAGES+3 `clk` periods, i.e. fspi ≤ fclk/10 at default settings. Register fetch completes before the next falling edge.
- **`busy`.** Rises on the cycle `spi_cs` low is detected. Falls on the cycle `spi_cs` high is detected.

## Test plan
- **Single write.** Frame 0x05 then 0xA5 (write, ms = 0, addr 5) -> one `wr_strobe` with `wr_addr` = 5 and `wr_data` = 0xA5; then a read of 0x85 returns 0xA5 on MISO, LSB first.
- **Burst write with wrap.** Frame 0x7E followed by 0x11, 0x22, 0x33 (ms = 1, addr 62) -> writes regs 62, 63 and 0 attempted; 62 = 0x11, 63 = 0x22; reg 0 unchanged with no third strobe; a read of reg 0 returns 0x33 (`DEVICE_ID`).
- **Truncated frame.** Address byte 0x09, then 4 data bits, then CS high -> `frame_err` pulses once, reg 9 unchanged, no `wr_strobe`, and the next frame decodes normally.
- **Write collision.** SPI commit and `loc_we` to addr 7 in the same cycle with values 0x3C and 0xC3 -> reg 7 = 0x3C. With `loc_we` to addr 8 in the same cycle instead -> reg 8 = 0xC3 and reg 7 = 0x3C.
- **Single-byte read then drain.** Read frame 0x87 with 16 data clocks and ms = 0 -> the first byte carries reg 7; the second byte is 0x00; exactly one `rd_strobe`.
- **Reset mid-frame.** Assert `rst` for 2 cycles during the address byte with CS held low -> outputs 0, no writes, frame ignored until CS high; the following frame is correct.
